// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory response block.
package dmem_pkg;

   localparam int unsigned DefaultLatency = 2;

   typedef enum logic [2:0] {
      F3Byte  = 3'b000,
      F3Half  = 3'b001,
      F3Word  = 3'b010,
      F3ByteU = 3'b100,
      F3HalfU = 3'b101
   } funct3_e;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StWait = 2'd1,
      StResp = 2'd2
   } state_e;

   // Unlisted codes fault, as do the unsigned variants when used for a store.
   function automatic logic funct3_illegal(input logic [2:0] funct3, input logic we);
      case (funct3)
         F3Byte, F3Half, F3Word: return 1'b0;
         F3ByteU, F3HalfU:       return we;
         default:                return 1'b1;
      endcase
   endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: store mask/replicated data, and load extraction with sign/zero extension.
module dmem_lane_align
   import dmem_pkg::*;
(
   input  logic [1:0]  addr_lo_i,
   input  logic [2:0]  funct3_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] rword_i,
   output logic [3:0]  wmask_o,
   output logic [31:0] wdata_o,
   output logic [31:0] rdata_o
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   always_comb begin
      byte_v  = rword_i[{addr_lo_i, 3'b000} +: 8];
      half_v  = rword_i[{addr_lo_i[1], 4'b0000} +: 16];
      wmask_o = '0;
      wdata_o = '0;
      rdata_o = '0;
      // Sub-word offsets are aligned down; misalignment faults are decided by the caller.
      case (funct3_i)
         F3Byte, F3ByteU: begin
            wmask_o = 4'b0001 << addr_lo_i;
            wdata_o = {4{wdata_i[7:0]}};
            rdata_o = {{24{byte_v[7] & ~funct3_i[2]}}, byte_v};
         end
         F3Half, F3HalfU: begin
            wmask_o = 4'b0011 << {addr_lo_i[1], 1'b0};
            wdata_o = {2{wdata_i[15:0]}};
            rdata_o = {{16{half_v[15] & ~funct3_i[2]}}, half_v};
         end
         F3Word: begin
            wmask_o = 4'b1111;
            wdata_o = wdata_i;
            rdata_o = rword_i;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/data_mem_resp.sv
// Data memory with one outstanding load/store and a fixed LATENCY to a one-cycle response.
// Define DMEM_MISALIGN_CHECK_EN to fault misaligned half/word accesses instead of aligning down.
module data_mem_resp
   import dmem_pkg::*;
#(
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned ADDR_WIDTH  = 32,
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned LATENCY     = DefaultLatency
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  req_valid_i,
   output logic                  req_ready_o,
   input  logic                  req_we_i,
   input  logic [ADDR_WIDTH-1:0] req_addr_i,
   input  logic [DATA_WIDTH-1:0] req_wdata_i,
   input  logic [2:0]            req_funct3_i,
   output logic                  resp_valid_o,
   output logic [DATA_WIDTH-1:0] resp_rdata_o,
   output logic                  resp_err_o,
   output logic                  stall_o
);

   localparam int unsigned IdxW     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam int unsigned CntW     = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic [63:0] MemBytes = 64'(DEPTH_WORDS) * 64'd4;

   if (LATENCY == 0) begin : g_bad_latency
      $error("data_mem_resp: LATENCY must be at least 1");
   end
   if (DATA_WIDTH != 32) begin : g_bad_width
      $error("data_mem_resp: DATA_WIDTH must be 32");
   end
   if (ADDR_WIDTH < IdxW + 2) begin : g_bad_addr
      $error("data_mem_resp: ADDR_WIDTH too small for DEPTH_WORDS");
   end

   state_e                state_q, state_d;
   logic [CntW-1:0]       cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                  err_q, err_d;

   logic [ADDR_WIDTH-1:0] addr_q;
   logic                  we_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [2:0]            funct3_q;

   logic [31:0]           mem_q [DEPTH_WORDS];

   logic                  accept;
   logic                  access;
   logic                  acc_err;
   logic                  misalign;
   logic                  do_write;
   logic [IdxW-1:0]       word_idx;
   logic [3:0]            wmask;
   logic [31:0]           wdata_sh;
   logic [DATA_WIDTH-1:0] load_data;

`ifdef DMEM_MISALIGN_CHECK_EN
   assign misalign = ((funct3_q == F3Half || funct3_q == F3HalfU) && addr_q[0])
                     || (funct3_q == F3Word && addr_q[1:0] != 2'b00);
`else
   assign misalign = 1'b0;
`endif

   assign word_idx = addr_q[IdxW+1:2];
   assign acc_err  = funct3_illegal(funct3_q, we_q) | (64'(addr_q) >= MemBytes) | misalign;

   assign req_ready_o  = (state_q == StIdle) & ~rst_i;
   assign accept       = req_valid_i & req_ready_o;
   assign access       = (state_q == StWait) && (cnt_q == '0);
   // A reset on the access edge aborts the pending store.
   assign do_write     = access & we_q & ~acc_err & ~rst_i;
   assign stall_o      = (state_q == StWait) | ((state_q == StIdle) & req_valid_i);
   assign resp_valid_o = (state_q == StResp);
   assign resp_rdata_o = rdata_q;
   assign resp_err_o   = err_q;

   dmem_lane_align u_lane_align (
      .addr_lo_i (addr_q[1:0]),
      .funct3_i  (funct3_q),
      .wdata_i   (wdata_q),
      .rword_i   (mem_q[word_idx]),
      .wmask_o   (wmask),
      .wdata_o   (wdata_sh),
      .rdata_o   (load_data)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rdata_d = '0;
      err_d   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               state_d = StWait;
               cnt_d   = CntW'(LATENCY - 1);
            end
         end
         StWait: begin
            if (cnt_q == '0) begin
               state_d = StResp;
               err_d   = acc_err;
               rdata_d = (acc_err | we_q) ? '0 : load_data;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         StResp:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (accept) begin
         addr_q   <= req_addr_i;
         we_q     <= req_we_i;
         wdata_q  <= req_wdata_i;
         funct3_q <= req_funct3_i;
      end
   end

   // Storage is deliberately left out of reset.
   always_ff @(posedge clk_i) begin
      if (do_write) begin
         for (int i = 0; i < 4; i++) begin
            if (wmask[i]) mem_q[word_idx][8*i +: 8] <= wdata_sh[8*i +: 8];
         end
      end
   end

endmodule
